spi_frame_port: RTL and testbench

Parametrised SPI slave frame port for the job/config/result interfaces of the hashing core. It replaces fixed-width, hard-wired SPI shifters. All pins are oversampled in the core clock domain, and SPI mode 0 is used. Each port receives a RX_BITS-wide frame, commits it on chip-select release with a valid strobe or an error flag, and shifts out a TX_BITS-wide result. Received bits pass through behind the TX word for daisy chaining. Used once per SPI port in top (global job bus, daisy config/result bus).

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_frame_port_sync_edge.sv | 30 +++
 rtl/spi_frame_port.sv | 176 +++++++++++++++++
 tb/tb_spi_frame_port.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame port and its synchronisers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

  // Frame FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Idle levels of the SPI pins, loaded into the synchronisers on reset
  localparam logic SCK_RST_VAL = 1'b0;
  localparam logic SDI_RST_VAL = 1'b0;
  localparam logic CS_RST_VAL  = 1'b1;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_frame_port_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall pulses.
// Latency: edge pulse visible STAGES-1 cycles after the pin moves; acted on at edge STAGES.
// Backpressure: none; pulses are single-cycle and must be consumed immediately.
module sync_edge #(
  parameter int   STAGES    = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;

  // Shift the pin through the synchroniser chain; stage 0 is the metastable one
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  // Edges are judged between the last two stages so both inputs are settled
  assign o_rise = r_sync[STAGES-2] & ~r_sync[STAGES-1];
  assign o_fall = ~r_sync[STAGES-2] & r_sync[STAGES-1];

endmodule

// File: rtl/spi_frame_port.sv
// SPI mode-0 slave frame port: receives RX_BITS, commits on cs release, shifts out TX_BITS then daisy data.
// Latency: pin-to-action SYNC_STAGES clk cycles; rx_valid_out pulses in the cycle after cs rise is seen.
// Backpressure: none; the SPI master owns timing, tx_load_in is dropped unless the port is idle.
module spi_frame_port
  import spi_pkg::*;
#(
  parameter int RX_BITS     = 360,
  parameter int TX_BITS     = 32,
  parameter int SYNC_STAGES = 3,
  parameter int MSB_FIRST   = 1,
  parameter int ALLOW_LONG  = 1
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic               sck_in,
  input  logic               sdi_in,
  input  logic               cs_n_in,
  output logic               sdo_out,
  output logic [RX_BITS-1:0] rx_data_out,
  output logic               rx_valid_out,
  output logic               rx_error_out,
  input  logic [TX_BITS-1:0] tx_data_in,
  input  logic               tx_load_in,
  output logic               tx_busy_out
);

  // Counter holds 0..RX_BITS+1; the top value is sticky so overlong frames never alias to RX_BITS
  localparam int               CNT_W   = clog2(RX_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_RX  = CNT_W'(RX_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RX_BITS + 1);

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [RX_BITS-1:0]         r_rx_shift;
  logic [TX_BITS-1:0]         r_tx_shift;
  logic [RX_BITS-1:0]         r_rx_data;
  logic                       r_rx_valid;
  logic                       r_rx_error;
  logic                       r_busy;
  logic [SYNC_STAGES-1:0]     r_sdi_sync;

  logic                       w_sck_rise;
  logic                       w_sck_fall;
  logic                       w_cs_rise;
  logic                       w_cs_fall;
  logic                       w_sdi;
  logic                       w_fill;
  logic                       w_len_ok;
  logic [RX_BITS-1:0]         w_rx_next;
  logic [TX_BITS-1:0]         w_tx_next;

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (SCK_RST_VAL)
  ) u_sck_sync (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .i_async    (sck_in),
    .o_rise     (w_sck_rise),
    .o_fall     (w_sck_fall)
  );

  sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (CS_RST_VAL)
  ) u_cs_sync (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .i_async    (cs_n_in),
    .o_rise     (w_cs_rise),
    .o_fall     (w_cs_fall)
  );

  // Data pin needs only a level; it is stable for a full sck phase around the sampling edge
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sdi_sync <= {SYNC_STAGES{SDI_RST_VAL}};
    end else begin
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi_in};
    end
  end

  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  // The most recently received bit refills the TX shifter, so sdo replays sdi TX_BITS bits later
  assign w_fill = (MSB_FIRST != 0) ? r_rx_shift[0] : r_rx_shift[RX_BITS-1];

  generate
    if (RX_BITS == 1) begin : g_rx1
      assign w_rx_next = w_sdi;
    end else if (MSB_FIRST != 0) begin : g_rx_msb
      assign w_rx_next = {r_rx_shift[RX_BITS-2:0], w_sdi};
    end else begin : g_rx_lsb
      assign w_rx_next = {w_sdi, r_rx_shift[RX_BITS-1:1]};
    end

    if (TX_BITS == 1) begin : g_tx1
      assign w_tx_next = w_fill;
    end else if (MSB_FIRST != 0) begin : g_tx_msb
      assign w_tx_next = {r_tx_shift[TX_BITS-2:0], w_fill};
    end else begin : g_tx_lsb
      assign w_tx_next = {w_fill, r_tx_shift[TX_BITS-1:1]};
    end
  endgenerate

  assign w_len_ok = (r_cnt == CNT_RX) || ((ALLOW_LONG != 0) && (r_cnt > CNT_RX));

  // Frame FSM: counts bits while cs is low, commits or flags an error on cs release
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_error <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_load_in) begin
            r_tx_shift <= tx_data_in;
          end
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_busy     <= 1'b1;
            r_rx_error <= 1'b0;
            // A bit arriving with the select edge counts after the clear
            if (w_sck_rise) begin
              r_rx_shift <= w_rx_next;
              r_cnt      <= CNT_W'(1);
            end else begin
              r_cnt      <= '0;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            // Any sck edge coinciding with cs release is outside the frame
            r_state <= ST_COMMIT;
            if (w_len_ok) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_error <= 1'b1;
            end
          end else if (w_sck_rise) begin
            r_rx_shift <= w_rx_next;
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_sck_fall) begin
            r_tx_shift <= w_tx_next;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sdo_out      = (MSB_FIRST != 0) ? r_tx_shift[TX_BITS-1] : r_tx_shift[0];
  assign rx_data_out  = r_rx_data;
  assign rx_valid_out = r_rx_valid;
  assign rx_error_out = r_rx_error;
  assign tx_busy_out  = r_busy;

endmodule

// File: tb/tb_spi_frame_port.sv
// Directed bench for spi_frame_port: 8/8 port, 360/32 long-frame port, 360/32 strict-length port.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_frame_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sck;
  logic sdi;
  logic cs8, csl, css;
  logic [7:0]  tx8;
  logic        ld8;
  logic [31:0] txl;
  logic        ldl;

  logic         sdo8, v8, e8, b8;
  logic [7:0]   rxd8;
  logic         sdol, vl, el, bl;
  logic [359:0] rxdl;
  logic         sdos, vs, es, bs;
  logic [359:0] rxds;

  spi_frame_port #(.RX_BITS(8), .TX_BITS(8), .SYNC_STAGES(3), .MSB_FIRST(1), .ALLOW_LONG(1)) u_dut8 (
    .clk_in(clk), .reset_n_in(rst_n), .sck_in(sck), .sdi_in(sdi), .cs_n_in(cs8),
    .sdo_out(sdo8), .rx_data_out(rxd8), .rx_valid_out(v8), .rx_error_out(e8),
    .tx_data_in(tx8), .tx_load_in(ld8), .tx_busy_out(b8)
  );

  spi_frame_port #(.RX_BITS(360), .TX_BITS(32), .SYNC_STAGES(3), .MSB_FIRST(1), .ALLOW_LONG(1)) u_dut_long (
    .clk_in(clk), .reset_n_in(rst_n), .sck_in(sck), .sdi_in(sdi), .cs_n_in(csl),
    .sdo_out(sdol), .rx_data_out(rxdl), .rx_valid_out(vl), .rx_error_out(el),
    .tx_data_in(txl), .tx_load_in(ldl), .tx_busy_out(bl)
  );

  spi_frame_port #(.RX_BITS(360), .TX_BITS(32), .SYNC_STAGES(3), .MSB_FIRST(1), .ALLOW_LONG(0)) u_dut_strict (
    .clk_in(clk), .reset_n_in(rst_n), .sck_in(sck), .sdi_in(sdi), .cs_n_in(css),
    .sdo_out(sdos), .rx_data_out(rxds), .rx_valid_out(vs), .rx_error_out(es),
    .tx_data_in(txl), .tx_load_in(ldl), .tx_busy_out(bs)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Cycles with rx_valid_out high, per port
  int vc8 = 0;
  int vcl = 0;
  int vcs = 0;
  always @(negedge clk) begin
    if (v8) vc8++;
    if (vl) vcl++;
    if (vs) vcs++;
  end

  logic [15:0]  cap8;
  logic         busy_ok;
  logic [367:0] pat;
  logic [367:0] pat2;
  int           snap8, snapl, snaps;

  task automatic check_val(input string tag, input logic [359:0] got, input logic [359:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load8(input logic [7:0] val);
    tx8 = val;
    ld8 = 1'b1;
    wait_clk(1);
    ld8 = 1'b0;
    wait_clk(1);
  endtask

  // One framed transfer: sel bit0 = 8-bit port, bit1 = long port, bit2 = strict port.
  // Sends data[n-1] first; captures the 8-bit port's sdo just before each sck rise.
  // If load_at matches a bit index, pulses a 0xFF load into the 8-bit port during that bit.
  task automatic xfer(input logic [2:0] sel, input logic [367:0] data, input int n, input int load_at);
    cap8    = '0;
    busy_ok = 1'b1;
    cs8 = ~sel[0];
    csl = ~sel[1];
    css = ~sel[2];
    wait_clk(6);
    for (int i = 0; i < n; i++) begin
      sdi = data[n-1-i];
      if (i == load_at) begin
        tx8 = 8'hFF;
        ld8 = 1'b1;
        wait_clk(1);
        ld8 = 1'b0;
        wait_clk(3);
      end else begin
        wait_clk(4);
      end
      cap8 = {cap8[14:0], sdo8};
      if (sel[0] && !b8) busy_ok = 1'b0;
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
    wait_clk(4);
    cs8 = 1'b1;
    csl = 1'b1;
    css = 1'b1;
    wait_clk(8);
  endtask

  initial begin : main
    logic [31:0] x;
    x = 32'h1234_5679;
    for (int i = 0; i < 368; i++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      pat[i]  = x[0];
      pat2[i] = x[7];
    end

    rst_n = 1'b0;
    sck = 1'b0; sdi = 1'b0;
    cs8 = 1'b1; csl = 1'b1; css = 1'b1;
    tx8 = 8'h00; ld8 = 1'b0;
    txl = 32'h0; ldl = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);

    // Reset state
    check_val("rst_rx_data8", rxd8, 360'h0);
    check_val("rst_valid8",   v8,   360'h0);
    check_val("rst_error8",   e8,   360'h0);
    check_val("rst_busy8",    b8,   360'h0);
    check_val("rst_sdo8",     sdo8, 360'h0);
    check_val("rst_rx_datal", rxdl, 360'h0);

    // Exact 8-bit frame 0xA5
    snap8 = vc8;
    xfer(3'b001, 368'hA5, 8, -1);
    check_val("a5_valid_cycles", vc8 - snap8, 360'd1);
    check_val("a5_data",  rxd8, 360'hA5);
    check_val("a5_error", e8,   360'h0);
    check_val("a5_busy_during", busy_ok, 360'h1);
    check_val("a5_busy_after",  b8,      360'h0);

    // Short frame: 5 bits
    snap8 = vc8;
    xfer(3'b001, 368'h1B, 5, -1);
    check_val("short_no_valid", vc8 - snap8, 360'd0);
    check_val("short_error",    e8,   360'h1);
    check_val("short_data_held", rxd8, 360'hA5);

    // Next cs fall clears the sticky error; an empty frame sets it again
    cs8 = 1'b0;
    wait_clk(6);
    check_val("csfall_err_clear", e8, 360'h0);
    check_val("csfall_busy",      b8, 360'h1);
    cs8 = 1'b1;
    wait_clk(8);
    check_val("empty_error", e8, 360'h1);
    check_val("empty_data_held", rxd8, 360'hA5);

    // Daisy: load 0x3C, 16 bits of 0xF0 then 0x00; saturated overlong frame still commits
    load8(8'h3C);
    snap8 = vc8;
    xfer(3'b001, 368'hF000, 16, -1);
    check_val("daisy_sdo", cap8, 360'h3CF0);
    check_val("daisy_valid_cycles", vc8 - snap8, 360'd1);
    check_val("daisy_data", rxd8, 360'h00);
    check_val("daisy_error", e8, 360'h0);

    // 368-bit frame into both 360-bit ports
    snapl = vcl;
    snaps = vcs;
    xfer(3'b110, pat, 368, -1);
    check_val("long_valid_cycles", vcl - snapl, 360'd1);
    check_val("long_data",  rxdl, pat[359:0]);
    check_val("long_error", el,   360'h0);
    check_val("strict_long_no_valid", vcs - snaps, 360'd0);
    check_val("strict_long_error",    es,   360'h1);
    check_val("strict_long_data",     rxds, 360'h0);

    // Exact 360 into the strict port, then 361
    snaps = vcs;
    xfer(3'b100, pat, 360, -1);
    check_val("strict_exact_valid", vcs - snaps, 360'd1);
    check_val("strict_exact_data",  rxds, pat[359:0]);
    check_val("strict_exact_error", es,   360'h0);
    snaps = vcs;
    xfer(3'b100, pat2, 361, -1);
    check_val("strict_361_no_valid", vcs - snaps, 360'd0);
    check_val("strict_361_error",    es,   360'h1);
    check_val("strict_361_data_held", rxds, pat[359:0]);

    // Reset after 4 of 8 bits
    xfer(3'b001, 368'h5A, 8, -1);
    check_val("pre_reset_data", rxd8, 360'h5A);
    load8(8'hC3);
    snap8 = vc8;
    cs8 = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 4; i++) begin
      sdi = i[0];
      wait_clk(4);
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check_val("midrst_data",  rxd8, 360'h0);
    check_val("midrst_valid", v8,   360'h0);
    check_val("midrst_error", e8,   360'h0);
    check_val("midrst_busy",  b8,   360'h0);
    check_val("midrst_sdo",   sdo8, 360'h0);
    cs8 = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(5);
    check_val("midrst_no_commit", vc8 - snap8, 360'd0);
    snap8 = vc8;
    xfer(3'b001, 368'h96, 8, -1);
    check_val("post_rst_valid", vc8 - snap8, 360'd1);
    check_val("post_rst_data",  rxd8, 360'h96);
    check_val("post_rst_error", e8,   360'h0);

    // Load pulsed mid-frame is ignored
    load8(8'h81);
    xfer(3'b001, 368'h00, 8, 3);
    check_val("midload_sdo",  cap8[7:0], 360'h81);
    check_val("midload_busy", busy_ok,   360'h1);
    check_val("midload_data", rxd8,      360'h00);
    load8(8'h80);
    check_val("idle_load_sdo", sdo8, 360'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case anything above stalls
  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
